exc_collector: RTL and testbench

- Parametrised successor to the single-source program-error latch.
- Collects NUM_CH independent exception request channels (program, alignment, DSI, ISI, syscall, external, ...) into sticky pending bits.
- Captures a per-channel cause code and faulting PC for each pending channel.
- Dispatches the highest-priority unmasked pending channel to the interrupt unit over a req/ack handshake.
- Sits between the decode/execute exception sources and the SRR0/SRR1/ESR update logic.

---
 rtl/exc_collector_pkg.sv | 28 ++
 rtl/exc_collector_if.sv | 26 ++
 rtl/exc_prio_enc.sv | 25 ++
 rtl/exc_collector.sv | 185 ++++++++++++++++++
 tb/tb_exc_collector.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_collector_pkg.sv
// Shared definitions for the exception collector.
// Contents:
//   - channel index constants;
//   - program-error cause code bit positions;
//   - dispatch FSM state encoding.
package exc_collector_pkg;

  // Exception channel indices (channel 0 is the highest priority)
  localparam int EXC_CH_PROG  = 0;
  localparam int EXC_CH_ALIGN = 1;
  localparam int EXC_CH_DSI   = 2;
  localparam int EXC_CH_ISI   = 3;
  localparam int EXC_CH_SC    = 4;
  localparam int EXC_CH_EXT   = 5;

  // Bit positions inside a program-error cause code
  localparam int PROG_ILLEGAL_BIT = 0;
  localparam int PROG_PRIV_BIT    = 1;
  localparam int PROG_TRAP_BIT    = 2;

  // Dispatch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } excState_e;

endpackage

// File: rtl/exc_collector_if.sv
// Dispatch handshake between the exception collector and the interrupt unit.
// Signals:
//   - excReq  : dispatch request from the collector.
//   - excId   : index of the dispatched channel.
//   - excCode : captured cause code of the dispatched channel.
//   - excPC   : captured PC of the dispatched channel.
//   - ack     : interrupt unit accepts the dispatch.
// Modports:
//   - master : the collector side.
//   - slave  : the interrupt unit side.
interface exc_collector_if #(
  parameter int ID_W   = 3,
  parameter int CODE_W = 3,
  parameter int PC_W   = 32
) ();

  logic              excReq;
  logic [ID_W-1:0]   excId;
  logic [CODE_W-1:0] excCode;
  logic [PC_W-1:0]   excPC;
  logic              ack;

  modport master (output excReq, output excId, output excCode, output excPC, input ack);
  modport slave  (input excReq, input excId, input excCode, input excPC, output ack);

endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   - vec   : candidate vector; bit 0 has the highest priority.
//   - valid : at least one bit of vec is set.
//   - idx   : index of the lowest set bit (0 when valid is low).
module exc_prio_enc #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = 3
) (
  input  logic [NUM_CH-1:0] vec,
  output logic              valid,
  output logic [ID_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = {ID_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      valid = valid | vec[i];
      idx   = vec[i] ? ID_W'(i) : idx;
    end
  end

endmodule

// File: rtl/exc_collector.sv
// Exception collector.
// Function:
//   - Latches NUM_CH exception request channels into sticky pending bits.
//   - Captures the cause code and PC of the first request on each channel.
//   - Dispatches the lowest-index unmasked pending channel to the interrupt
//     unit over a req/ack handshake.
// Ports:
//   - clk, rst : clock; asynchronous active-high reset.
//   - req      : per-channel exception requests.
//   - code     : per-channel cause codes; channel i uses [i*CODE_W +: CODE_W].
//   - pc       : PC of the instruction raising a request this cycle.
//   - mask     : 1 = channel not eligible for dispatch.
//                A masked channel still becomes pending.
//   - flush    : drop every pending channel except the one being dispatched.
//   - dispIf   : dispatch handshake (excReq/excId/excCode/excPC out, ack in).
//   - pending  : sticky pending vector.
//   - excCnt   : per-channel accepted-handshake counters.
// Build option:
//   - EXC_COLLECTOR_CNT_EN : when defined, builds saturating per-channel
//     counters; otherwise excCnt is tied to 0.
module exc_collector
  import exc_collector_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CODE_W = 3,
  parameter int PC_W   = 32,
  parameter int ID_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*CODE_W-1:0] code,
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_CH-1:0]        mask,
  input  logic                     flush,
  exc_collector_if.master          dispIf,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH*CNT_W-1:0]  excCnt
);

  excState_e         state_r;
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] clr_s;
  logic [NUM_CH-1:0] dispHit_s;
  logic [NUM_CH-1:0] elig_s;
  logic [CODE_W-1:0] capCode_r [NUM_CH];
  logic [PC_W-1:0]   capPc_r   [NUM_CH];
  logic              selValid_s;
  logic [ID_W-1:0]   selId_s;
  logic              ackTake_s;
  logic              excReq_r;
  logic [ID_W-1:0]   excId_r;
  logic [CODE_W-1:0] excCode_r;
  logic [PC_W-1:0]   excPC_r;

  assign ackTake_s = (state_r == ST_REQ) && dispIf.ack;

  // A flush cycle must not pick a channel that the same edge is discarding
  assign elig_s = pending_r & ~mask & {NUM_CH{~flush}};

  exc_prio_enc #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) uPrioEnc (
    .vec   (elig_s),
    .valid (selValid_s),
    .idx   (selId_s)
  );

  // Per-channel set/clear terms.
  // A request on the channel being acked in the same cycle re-captures
  // (set wins over clear).
  always_comb begin
    dispHit_s = {NUM_CH{1'b0}};
    set_s     = {NUM_CH{1'b0}};
    clr_s     = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      dispHit_s[i] = (state_r == ST_REQ) && (excId_r == ID_W'(i));
      if (flush) begin
        clr_s[i] = ~dispHit_s[i] | ackTake_s;
        set_s[i] = 1'b0;
      end else begin
        clr_s[i] = dispHit_s[i] & ackTake_s;
        set_s[i] = req[i] & (~pending_r[i] | clr_s[i]);
      end
    end
  end

  // Sticky pending vector plus first-capture code/PC storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        capCode_r[i] <= {CODE_W{1'b0}};
        capPc_r[i]   <= {PC_W{1'b0}};
      end
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (set_s[i]) begin
          capCode_r[i] <= code[i*CODE_W +: CODE_W];
          capPc_r[i]   <= pc;
        end
      end
    end
  end

  // Dispatch FSM.
  // Outputs are registered when a channel is selected and held until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      excReq_r  <= 1'b0;
      excId_r   <= {ID_W{1'b0}};
      excCode_r <= {CODE_W{1'b0}};
      excPC_r   <= {PC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (selValid_s) begin
            excId_r   <= selId_s;
            excCode_r <= capCode_r[selId_s];
            excPC_r   <= capPc_r[selId_s];
            excReq_r  <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dispIf.ack) begin
            excReq_r <= 1'b0;
            state_r  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          excReq_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign dispIf.excReq  = excReq_r;
  assign dispIf.excId   = excId_r;
  assign dispIf.excCode = excCode_r;
  assign dispIf.excPC   = excPC_r;
  assign pending        = pending_r;

`ifdef EXC_COLLECTOR_CNT_EN
  logic [CNT_W-1:0]        cnt_r [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] cntFlat_s;

  // Saturating count of accepted handshakes per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (dispHit_s[i] && ackTake_s && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten the counter array onto the output bus
  always_comb begin
    cntFlat_s = {(NUM_CH*CNT_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cntFlat_s[i*CNT_W +: CNT_W] = cnt_r[i];
    end
  end

  assign excCnt = cntFlat_s;
`else
  assign excCnt = {(NUM_CH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_exc_collector.sv
// Self-checking bench for exc_collector.
// Expected dispatches are queued when requests are driven and compared when
// excReq is seen. Counter expectations follow EXC_COLLECTOR_CNT_EN.
module tb_exc_collector;
  import exc_collector_pkg::*;

  typedef struct {
    logic [2:0]  id;
    logic [2:0]  code;
    logic [31:0] pc;
  } dispExp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [23:0] code;
  logic [31:0] pc;
  logic [7:0]  mask;
  logic        flush;
  logic [7:0]  pending;
  logic [63:0] excCnt;

  int       nChecks = 0;
  int       nFail   = 0;
  dispExp_t sbQ[$];
  int       cntExp[8];

  exc_collector_if #(.ID_W(3), .CODE_W(3), .PC_W(32)) dIf ();

  exc_collector #(
    .NUM_CH (8),
    .CODE_W (3),
    .PC_W   (32),
    .ID_W   (3),
    .CNT_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .code    (code),
    .pc      (pc),
    .mask    (mask),
    .flush   (flush),
    .dispIf  (dIf),
    .pending (pending),
    .excCnt  (excCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic dispExp_t mkExp(input int id, input logic [2:0] c, input logic [31:0] p);
    dispExp_t e;
    e.id   = 3'(id);
    e.code = c;
    e.pc   = p;
    return e;
  endfunction

  // Wait (bounded) for excReq and compare against the scoreboard head
  task automatic expectDispatch(input string tag, input int budget, output int waited);
    dispExp_t e;
    waited = 0;
    while (dIf.excReq !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (dIf.excReq !== 1'b1) begin
      checkVal($sformatf("%s timeout", tag), 64'(dIf.excReq), 64'd1);
    end else if (sbQ.size() == 0) begin
      checkVal($sformatf("%s unexpected", tag), 64'd1, 64'd0);
    end else begin
      e = sbQ.pop_front();
      checkVal($sformatf("%s id", tag), 64'(dIf.excId), 64'(e.id));
      checkVal($sformatf("%s code", tag), 64'(dIf.excCode), 64'(e.code));
      checkVal($sformatf("%s pc", tag), 64'(dIf.excPC), 64'(e.pc));
    end
  endtask

  // One-cycle ack at the current negedge; updates the counter model
  task automatic ackNow();
    int id;
    id = int'(dIf.excId);
    dIf.ack = 1'b1;
    @(negedge clk);
    dIf.ack = 1'b0;
`ifdef EXC_COLLECTOR_CNT_EN
    if (cntExp[id] != 255) cntExp[id]++;
`else
    id = 0;
`endif
  endtask

  task automatic checkCounters(input string tag);
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("%s cnt%0d", tag, i), 64'(excCnt[i*8 +: 8]), 64'(cntExp[i]));
    end
  endtask

  initial begin
    int w;
    logic [2:0] c;
    logic seen;

    for (int i = 0; i < 8; i++) cntExp[i] = 0;
    rst = 1'b1; req = 8'h00; code = 24'h0; pc = 32'h0;
    mask = 8'h00; flush = 1'b0; dIf.ack = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rst excReq", 64'(dIf.excReq), 64'd0);
    checkVal("rst excId", 64'(dIf.excId), 64'd0);
    checkVal("rst pending", 64'(pending), 64'd0);
    checkVal("rst excCnt", excCnt, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request on the DSI channel, cycle-exact latency
    c = 3'b000; c[PROG_PRIV_BIT] = 1'b1;
    req = 8'h00; req[EXC_CH_DSI] = 1'b1;
    code = 24'h0; code[EXC_CH_DSI*3 +: 3] = c; pc = 32'h100;
    sbQ.push_back(mkExp(EXC_CH_DSI, c, 32'h100));
    @(negedge clk);
    req = 8'h00;
    checkVal("t1 pending c1", 64'(pending), 64'h04);
    checkVal("t1 excReq c1", 64'(dIf.excReq), 64'd0);
    @(negedge clk);
    expectDispatch("t1 c2", 0, w);
    @(negedge clk);
    checkVal("t1 excReq c3", 64'(dIf.excReq), 64'd1);
    @(negedge clk);
    ackNow();
    checkVal("t1 excReq c5", 64'(dIf.excReq), 64'd0);
    checkVal("t1 pending c5", 64'(pending), 64'd0);

    // Priority: channels 2 and 5 together
    req = 8'b0010_0100; code = 24'h0;
    code[2*3 +: 3] = 3'b001; code[5*3 +: 3] = 3'b110; pc = 32'h300;
    sbQ.push_back(mkExp(2, 3'b001, 32'h300));
    sbQ.push_back(mkExp(5, 3'b110, 32'h300));
    @(negedge clk);
    req = 8'h00;
    expectDispatch("t2 first", 3, w);
    ackNow();
    expectDispatch("t2 second", 5, w);
    checkVal("t2 gap", 64'(w), 64'd2);
    ackNow();

    // First capture wins
    req = 8'h01; code = 24'h0; code[2:0] = 3'b001; pc = 32'h200;
    sbQ.push_back(mkExp(0, 3'b001, 32'h200));
    @(negedge clk);
    code[2:0] = 3'b100; pc = 32'h204;
    @(negedge clk);
    req = 8'h00;
    expectDispatch("t3", 3, w);
    ackNow();

    // Mask holds a pending channel; ack outside REQ is ignored
    repeat (3) @(negedge clk);
    mask = 8'h00; mask[EXC_CH_EXT] = 1'b1;
    req = 8'h00; req[EXC_CH_EXT] = 1'b1;
    code = 24'h0; code[EXC_CH_EXT*3 +: 3] = 3'b011; pc = 32'h500;
    @(negedge clk);
    req = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dIf.ack = (i % 4 == 1);
      @(negedge clk);
      seen = seen | dIf.excReq;
    end
    dIf.ack = 1'b0;
    checkVal("t4 masked excReq", 64'(seen), 64'd0);
    checkVal("t4 masked pending", 64'(pending), 64'h20);
    mask = 8'h00;
    sbQ.push_back(mkExp(EXC_CH_EXT, 3'b011, 32'h500));
    @(negedge clk);
    expectDispatch("t4 unmask", 0, w);
    ackNow();

    // Flush during REQ keeps only the dispatched channel; same-cycle req dropped
    repeat (3) @(negedge clk);
    req = 8'b0000_1010; code = 24'h0;
    code[1*3 +: 3] = 3'b101; code[3*3 +: 3] = 3'b010; pc = 32'h600;
    sbQ.push_back(mkExp(1, 3'b101, 32'h600));
    @(negedge clk);
    req = 8'h00;
    expectDispatch("t5", 3, w);
    flush = 1'b1; req = 8'h10; pc = 32'h6F0;
    @(negedge clk);
    flush = 1'b0; req = 8'h00;
    checkVal("t5 pending", 64'(pending), 64'h02);
    checkVal("t5 excReq", 64'(dIf.excReq), 64'd1);
    checkVal("t5 excId", 64'(dIf.excId), 64'd1);
    checkVal("t5 excCode", 64'(dIf.excCode), 64'h5);
    checkVal("t5 excPC", 64'(dIf.excPC), 64'h600);
    ackNow();
    checkVal("t5 pending after ack", 64'(pending), 64'd0);
    repeat (4) @(negedge clk);
    checkVal("t5 idle excReq", 64'(dIf.excReq), 64'd0);

    // Same-cycle ack and req on the dispatched channel: re-capture
    req = 8'h08; code = 24'h0; code[3*3 +: 3] = 3'b001; pc = 32'h700;
    sbQ.push_back(mkExp(3, 3'b001, 32'h700));
    @(negedge clk);
    req = 8'h00;
    expectDispatch("t6 first", 3, w);
    req = 8'h08; code[3*3 +: 3] = 3'b110; pc = 32'h704;
    sbQ.push_back(mkExp(3, 3'b110, 32'h704));
    ackNow();
    req = 8'h00;
    checkVal("t6 pending", 64'(pending), 64'h08);
    expectDispatch("t6 second", 4, w);
    ackNow();

    // All channels pending and masked, then ascending dispatch
    repeat (3) @(negedge clk);
    mask = 8'hFF; req = 8'hFF; pc = 32'h800;
    for (int i = 0; i < 8; i++) code[i*3 +: 3] = 3'(i);
    @(negedge clk);
    req = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | dIf.excReq;
    end
    checkVal("t7 all masked excReq", 64'(seen), 64'd0);
    checkVal("t7 all pending", 64'(pending), 64'hFF);
    mask = 8'h00;
    for (int i = 0; i < 8; i++) sbQ.push_back(mkExp(i, 3'(i), 32'h800));
    for (int i = 0; i < 8; i++) begin
      expectDispatch($sformatf("t7 ch%0d", i), 4, w);
      ackNow();
    end
    checkVal("t7 pending drained", 64'(pending), 64'd0);

    // Many handshakes on channel 0 to reach counter saturation
    for (int i = 0; i < 300; i++) begin
      req = 8'h01; code = 24'h0; code[2:0] = 3'b111; pc = 32'h1000 + 32'(i * 4);
      sbQ.push_back(mkExp(0, 3'b111, 32'h1000 + 32'(i * 4)));
      @(negedge clk);
      req = 8'h00;
      expectDispatch("t8", 4, w);
      ackNow();
    end
    checkCounters("t8");

    // Asynchronous reset while in REQ
    repeat (3) @(negedge clk);
    req = 8'h40; code = 24'h0; code[6*3 +: 3] = 3'b010; pc = 32'h900;
    sbQ.push_back(mkExp(6, 3'b010, 32'h900));
    @(negedge clk);
    req = 8'h00;
    expectDispatch("t9", 3, w);
    #2 rst = 1'b1;
    #1;
    checkVal("t9 async excReq", 64'(dIf.excReq), 64'd0);
    checkVal("t9 async pending", 64'(pending), 64'd0);
    checkVal("t9 async excCnt", excCnt, 64'd0);
    for (int i = 0; i < 8; i++) cntExp[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("t9 post excReq", 64'(dIf.excReq), 64'd0);
    checkCounters("t9");

    checkVal("sb empty", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
